// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU with private HI/LO,
// MFHI/MFLO/MTHI/MTLO service and a hazard stall toward ID/EX.
// All state advances on the falling clock edge, in step with the pipeline latches.
module ex_muldiv_unit #(
  parameter int         DATA_WIDTH  = 32,
  parameter logic [1:0] RTYPE_ALUOP = 2'b10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            inALUOp,
  input  logic [5:0]            inFunction,
  input  logic [DATA_WIDTH-1:0] inDataRs,
  input  logic [DATA_WIDTH-1:0] inDataRt,
  output logic [DATA_WIDTH-1:0] outResult,
  output logic                  outResultValid,
  output logic                  outStall,
  output logic                  outBusy,
  output logic [DATA_WIDTH-1:0] outHi,
  output logic [DATA_WIDTH-1:0] outLo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_hi, r_lo;
  logic [W-1:0]    r_opnd;     // multiplicand or divisor magnitude
  logic [2*W-1:0]  r_acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [CW-1:0]   r_cnt;
  logic            r_isdiv, r_neg_lo, r_neg_hi;

  // Decode of the latched instruction
  logic w_rtype, w_start, w_mfhi, w_mflo, w_mthi, w_mtlo, w_hazard;
  logic w_signed, w_isdiv, w_rs_neg, w_rt_neg, w_last;
  logic [W-1:0] w_rs_mag, w_rt_mag;

  assign w_rtype  = (inALUOp == RTYPE_ALUOP);
  assign w_start  = w_rtype && (inFunction == 6'h18 || inFunction == 6'h19 ||
                                inFunction == 6'h1A || inFunction == 6'h1B);
  assign w_mfhi   = w_rtype && (inFunction == 6'h10);
  assign w_mthi   = w_rtype && (inFunction == 6'h11);
  assign w_mflo   = w_rtype && (inFunction == 6'h12);
  assign w_mtlo   = w_rtype && (inFunction == 6'h13);
  assign w_hazard = w_start | w_mfhi | w_mflo | w_mthi | w_mtlo;

  assign w_signed = ~inFunction[0];   // MULT/DIV even, MULTU/DIVU odd
  assign w_isdiv  = inFunction[1];
  assign w_rs_neg = w_signed & inDataRs[W-1];
  assign w_rt_neg = w_signed & inDataRt[W-1];
  assign w_rs_mag = w_rs_neg ? -inDataRs : inDataRs;
  assign w_rt_mag = w_rt_neg ? -inDataRt : inDataRt;
  assign w_last   = (r_state == S_BUSY) && (r_cnt == CW'(W - 1));

  assign outBusy        = (r_state == S_BUSY);
  assign outStall       = outBusy & w_hazard;
  assign outResultValid = (w_mfhi | w_mflo) & ~outStall;
  assign outResult      = w_mfhi ? r_hi : (w_mflo ? r_lo : '0);
  assign outHi          = r_hi;
  assign outLo          = r_lo;

  // One iteration of shift-add multiply and restoring divide
  logic [W:0]     w_mul_sum, w_rem_sh;
  logic [W+1:0]   w_diff;
  logic [2*W-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
  logic [W-1:0]   w_q, w_r, w_hi_fin, w_lo_fin;
  logic           w_unused;

  assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[W-1:1]};
  assign w_rem_sh  = r_acc[2*W-1:W-1];
  assign w_diff    = {1'b0, w_rem_sh} - {2'b0, r_opnd};
  // A non-negative difference is below the divisor, so bit W is always zero there.
  assign w_div_nxt = w_diff[W+1] ? {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0}
                                 : {w_diff[W-1:0],   r_acc[W-2:0], 1'b1};
  assign w_unused  = w_diff[W];
  assign w_acc_nxt = r_isdiv ? w_div_nxt : w_mul_nxt;

  // Sign fixup applied to the final iteration's result
  assign w_prod   = r_neg_lo ? -w_acc_nxt : w_acc_nxt;
  assign w_q      = r_neg_lo ? -w_acc_nxt[W-1:0] : w_acc_nxt[W-1:0];
  assign w_r      = r_neg_hi ? -w_acc_nxt[2*W-1:W] : w_acc_nxt[2*W-1:W];
  assign w_hi_fin = r_isdiv ? w_r : w_prod[2*W-1:W];
  assign w_lo_fin = r_isdiv ? w_q : w_prod[W-1:0];

  // State register
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: accept a start op in IDLE, return after the last iteration
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, HI/LO writes
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_isdiv  <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_start) begin
        r_isdiv <= w_isdiv;
        r_cnt   <= '0;
        if (w_isdiv) begin
          r_opnd   <= w_rt_mag;
          r_acc    <= {{W{1'b0}}, w_rs_mag};
          // Divide by zero leaves an all-ones quotient unsigned-style.
          r_neg_lo <= (w_rs_neg ^ w_rt_neg) & (|inDataRt);
          r_neg_hi <= w_rs_neg;
        end else begin
          r_opnd   <= w_rs_mag;
          r_acc    <= {{W{1'b0}}, w_rt_mag};
          r_neg_lo <= w_rs_neg ^ w_rt_neg;
          r_neg_hi <= 1'b0;
        end
      end else begin
        if (w_mthi) r_hi <= inDataRs;
        if (w_mtlo) r_lo <= inDataRs;
      end
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_hi  <= w_hi_fin;
        r_lo  <= w_lo_fin;
        r_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: stimulus pushes expected MFHI/MFLO
// results into a queue, a monitor pops and compares on every valid read.
module tb_ex_muldiv_unit;
  logic        clk = 1'b1;
  logic        reset_n;
  logic [1:0]  inALUOp;
  logic [5:0]  inFunction;
  logic [31:0] inDataRs, inDataRt;
  logic [31:0] outResult, outHi, outLo;
  logic        outResultValid, outStall, outBusy;

  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
  localparam logic [5:0] ADD  = 6'h20, SUB = 6'h22;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int st;

  ex_muldiv_unit #(.DATA_WIDTH(32), .RTYPE_ALUOP(2'b10)) dut (
    .clk(clk), .reset_n(reset_n), .inALUOp(inALUOp), .inFunction(inFunction),
    .inDataRs(inDataRs), .inDataRt(inDataRt), .outResult(outResult),
    .outResultValid(outResultValid), .outStall(outStall), .outBusy(outBusy),
    .outHi(outHi), .outLo(outLo));

  // Falling edges at 5,15,...; inputs change on rising edges, sampling at +2.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an instruction and hold it until it is not stalled; st = stall cycles.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, output int stalls);
    @(posedge clk);
    inALUOp = op; inFunction = fn; inDataRs = rs; inDataRt = rt;
    stalls = 0;
    #2;
    while (outStall && stalls < 200) begin
      @(posedge clk);
      #2;
      stalls++;
    end
    if (stalls >= 200) chk("stall_timeout", 32'(stalls), 32'd0);
  endtask

  task automatic rop(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    issue(2'b10, fn, rs, rt, st);
  endtask

  // Issue an MFHI/MFLO expecting a given value and stall count.
  task automatic mf(input logic [5:0] fn, input logic [31:0] exp, input int exp_st,
                    input string name);
    exp_q.push_back(exp);
    issue(2'b10, fn, 32'h0, 32'h0, st);
    chk(name, 32'(st), 32'(exp_st));
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      inALUOp = 2'b00; inFunction = 6'h00; inDataRs = '0; inDataRt = '0;
    end
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (outResultValid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", outResult, 32'hxxxxxxxx);
        end else begin
          chk("read_result", outResult, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; inALUOp = 2'b00; inFunction = 6'h0; inDataRs = '0; inDataRt = '0;
    #12;
    chk("rst_busy", 32'(outBusy), 32'd0);
    chk("rst_hi", outHi, 32'h0);
    chk("rst_lo", outLo, 32'h0);
    chk("rst_stall", 32'(outStall), 32'd0);
    reset_n = 1'b1;
    nop(2);

    // Signed multiply, consumer immediately behind
    rop(MULT, 32'hFFFFFFFE, 32'h3);
    #4 chk("mult_busy", 32'(outBusy), 32'd1);
    mf(MFLO, 32'hFFFFFFFA, 32, "mult_lo_stalls");
    mf(MFHI, 32'hFFFFFFFF, 0, "mult_hi_stalls");
    chk("mult_dbg_hi", outHi, 32'hFFFFFFFF);

    rop(MULTU, 32'hFFFFFFFE, 32'h3);
    mf(MFHI, 32'h00000002, 32, "multu_hi_stalls");
    mf(MFLO, 32'hFFFFFFFA, 0, "multu_lo_stalls");

    rop(DIV, 32'hFFFFFFF9, 32'h2);
    mf(MFLO, 32'hFFFFFFFD, 32, "div_lo_stalls");
    mf(MFHI, 32'hFFFFFFFF, 0, "div_hi_stalls");

    rop(DIVU, 32'd100, 32'd7);
    mf(MFLO, 32'd14, 32, "divu_lo_stalls");
    mf(MFHI, 32'd2, 0, "divu_hi_stalls");

    rop(DIVU, 32'h12345678, 32'h0);
    mf(MFLO, 32'hFFFFFFFF, 32, "divz_lo_stalls");
    mf(MFHI, 32'h12345678, 0, "divz_hi_stalls");

    rop(DIV, 32'hFFFFFFF9, 32'h0);
    mf(MFLO, 32'hFFFFFFFF, 32, "sdivz_lo_stalls");
    mf(MFHI, 32'hFFFFFFF9, 0, "sdivz_hi_stalls");

    rop(DIV, 32'h80000000, 32'hFFFFFFFF);
    mf(MFLO, 32'h80000000, 32, "ovf_lo_stalls");
    mf(MFHI, 32'h00000000, 0, "ovf_hi_stalls");

    rop(MULT, 32'h80000000, 32'h80000000);
    mf(MFHI, 32'h40000000, 32, "mmin_hi_stalls");
    mf(MFLO, 32'h00000000, 0, "mmin_lo_stalls");

    // Unrelated instructions never stall while busy
    rop(MULTU, 32'd5, 32'd6);
    issue(2'b10, ADD, 32'd1, 32'd2, st); chk("add_nostall", 32'(st), 32'd0);
    issue(2'b10, SUB, 32'd1, 32'd2, st); chk("sub_nostall", 32'(st), 32'd0);
    issue(2'b00, MFLO, 32'd1, 32'd2, st); chk("lw_nostall", 32'(st), 32'd0);
    chk("nonr_busy", 32'(outBusy), 32'd1);
    nop(37);
    mf(MFHI, 32'd0, 0, "late_hi_stalls");
    mf(MFLO, 32'd30, 0, "late_lo_stalls");

    // MTLO while busy waits, then overwrites the product
    rop(MULTU, 32'd5, 32'd6);
    rop(MTLO, 32'hDEADBEEF, 32'h0);
    chk("mtlo_stalls", 32'(st), 32'd32);
    mf(MFLO, 32'hDEADBEEF, 0, "mtlo_read_stalls");
    mf(MFHI, 32'h0, 0, "mtlo_hi_stalls");

    rop(MTHI, 32'hCAFE0000, 32'h0);
    chk("mthi_nostall", 32'(st), 32'd0);
    mf(MFHI, 32'hCAFE0000, 0, "mthi_read_stalls");

    // Reset in the middle of a divide
    rop(DIVU, 32'd1000, 32'd3);
    nop(9);
    #2 chk("pre_rst_busy", 32'(outBusy), 32'd1);
    @(posedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(outBusy), 32'd0);
    chk("mid_rst_hi", outHi, 32'h0);
    chk("mid_rst_lo", outLo, 32'h0);
    @(posedge clk);
    reset_n = 1'b1;
    mf(MFLO, 32'h0, 0, "post_rst_stalls");

    nop(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
